// File: rtl/gbuf_arbiter.sv
// Two-requester arbiter for a shared global buffer.
// Round-robin in IDLE, with an optional bounded lock that holds ownership across cycles.
//
// state | meaning
// IDLE  | no owner; round-robin between requesters using last_grant
// LOCK0 | requester 0 owns the buffer; requester 1 is held off
// LOCK1 | requester 1 owns the buffer; requester 0 is held off
module gbuf_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int MAX_LOCK  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [DATA_BITS-1:0] req0_wdata,
  input  logic                 req0_lock,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [DATA_BITS-1:0] req1_wdata,
  input  logic                 req1_lock,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 bram_en,
  output logic                 bram_we,
  output logic [ADDR_BITS-1:0] bram_idx,
  output logic [DATA_BITS-1:0] bram_wdata,
  input  logic [DATA_BITS-1:0] bram_rdata
);

  localparam int CNT_BITS = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                last_grant, last_grant_nxt;
  logic [CNT_BITS-1:0] lock_cnt, lock_cnt_nxt;
  logic                rsp0_q, rsp1_q;
  logic                gnt0, gnt1;
  logic                cnt_max;

  assign cnt_max = (lock_cnt == CNT_BITS'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rsp0_q     <= gnt0 & ~req0_we;
      rsp1_q     <= gnt1 & ~req1_we;
    end
  end

  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    lock_cnt_nxt   = lock_cnt;
    case (state)
      IDLE: begin
        gnt0 = req0_valid & (~req1_valid | last_grant);
        gnt1 = req1_valid & (~req0_valid | ~last_grant);
        if (gnt0 && req0_lock) begin
          state_nxt    = LOCK0;
          lock_cnt_nxt = CNT_BITS'(1);
        end else if (gnt1 && req1_lock) begin
          state_nxt    = LOCK1;
          lock_cnt_nxt = CNT_BITS'(1);
        end
      end
      LOCK0: begin
        gnt0 = req0_valid;
        if (!req0_lock || cnt_max) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_BITS'(1);
        end
      end
      LOCK1: begin
        gnt1 = req1_valid;
        if (!req1_lock || cnt_max) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CNT_BITS'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) last_grant_nxt = 1'b0;
    if (gnt1) last_grant_nxt = 1'b1;
    // a forced release hands the next contention to the other requester
    if (state == LOCK0 && cnt_max) last_grant_nxt = 1'b0;
    if (state == LOCK1 && cnt_max) last_grant_nxt = 1'b1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign bram_en    = gnt0 | gnt1;
  assign bram_we    = (gnt0 & req0_we) | (gnt1 & req1_we);
  assign bram_idx   = gnt1 ? req1_addr : req0_addr;
  assign bram_wdata = gnt1 ? req1_wdata : req0_wdata;

  // a response pending across a reset cycle is dropped
  assign rsp0_valid = rsp0_q & ~rst;
  assign rsp1_valid = rsp1_q & ~rst;
  assign rsp_data   = bram_rdata;

endmodule

// File: tb/tb_gbuf_arbiter.sv
// Directed bench for gbuf_arbiter with a falling-edge buffer model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_gbuf_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req0_lock, req0_ready;
  logic       req1_valid, req1_we, req1_lock, req1_ready;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_data;
  logic       bram_en, bram_we;
  logic [7:0] bram_idx, bram_wdata;
  logic [7:0] bram_rdata;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  gbuf_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_idx(bram_idx),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_idx] <= bram_wdata;
      else         bram_rdata    <= mem[bram_idx];
    end
  end

  task automatic clr();
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready, bram_en, rsp0_valid, rsp1_valid} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: got rdy/en/rsp=%b want 00000", i,
                 {req0_ready, req1_ready, bram_en, rsp0_valid, rsp1_valid});
      end
      next_cycle();
    end
    rst = 0; clr();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g, exp_r;
    logic [7:0] exp_idx, exp_d;
    req0_valid = 1; req0_addr = 8'd3; req1_valid = 1; req1_addr = 8'd5;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) clr();
      @(negedge clk);
      exp_g   = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
      exp_r   = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b10 : 2'b01);
      exp_idx = (i % 2 == 0) ? 8'd3 : 8'd5;
      exp_d   = (i % 2 == 1) ? 8'h33 : 8'h55;
      n_cmp++;
      if ({req0_ready, req1_ready} !== exp_g || bram_en !== (exp_g != 2'b00)) begin
        n_bad++;
        $display("FAIL rr_grant cyc%0d: got rdy=%b en=%b want rdy=%b", i,
                 {req0_ready, req1_ready}, bram_en, exp_g);
      end
      if (i < 4) begin
        n_cmp++;
        if (bram_idx !== exp_idx) begin
          n_bad++;
          $display("FAIL rr_idx cyc%0d: got %0d want %0d", i, bram_idx, exp_idx);
        end
      end
      n_cmp++;
      if ({rsp0_valid, rsp1_valid} !== exp_r) begin
        n_bad++;
        $display("FAIL rr_rsp cyc%0d: got %b want %b", i, {rsp0_valid, rsp1_valid}, exp_r);
      end
      if (i > 0) begin
        n_cmp++;
        if (rsp_data !== exp_d) begin
          n_bad++;
          $display("FAIL rr_data cyc%0d: got %h want %h", i, rsp_data, exp_d);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_read();
    req0_valid = 1; req0_we = 1; req0_addr = 8'd7; req0_wdata = 8'hA5;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, bram_en, bram_we, bram_idx, bram_wdata} !== {4'b1011, 8'd7, 8'hA5}) begin
      n_bad++;
      $display("FAIL wr_issue: got rdy/en/we=%b idx=%0d wd=%h want 1011 7 a5",
               {req0_ready, req1_ready, bram_en, bram_we}, bram_idx, bram_wdata);
    end
    next_cycle();
    clr(); req1_valid = 1; req1_addr = 8'd7;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, bram_en, bram_we, rsp0_valid} !== 5'b01100) begin
      n_bad++;
      $display("FAIL rd_issue: got rdy/en/we/rsp0=%b want 01100",
               {req0_ready, req1_ready, bram_en, bram_we, rsp0_valid});
    end
    next_cycle();
    clr();
    @(negedge clk);
    n_cmp++;
    if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL rd_rsp: got rsp=%b data=%h want 01 a5", {rsp0_valid, rsp1_valid}, rsp_data);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL rd_rsp_once: got %b want 00", {rsp0_valid, rsp1_valid});
    end
    next_cycle();
  endtask

  task automatic test_lock0();
    logic [1:0] exp_g;
    req0_valid = 1; req0_we = 1; req0_lock = 1; req0_addr = 8'h10; req0_wdata = 8'h11;
    req1_valid = 1; req1_addr = 8'h20;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) req0_lock = 0;
      @(negedge clk);
      exp_g = (i < 6) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({req0_ready, req1_ready} !== exp_g) begin
        n_bad++;
        $display("FAIL lock0_grant cyc%0d: got %b want %b", i, {req0_ready, req1_ready}, exp_g);
      end
      next_cycle();
    end
    clr();
  endtask

  task automatic test_lock1_max();
    logic [1:0] exp_g;
    req1_valid = 1; req1_lock = 1; req1_addr = 8'h20;
    for (int i = 0; i < 19; i++) begin
      if (i == 1) req0_valid = 1;
      @(negedge clk);
      exp_g = (i == 17) ? 2'b10 : 2'b01;
      n_cmp++;
      if ({req0_ready, req1_ready} !== exp_g) begin
        n_bad++;
        $display("FAIL lock1_max cyc%0d: got %b want %b", i, {req0_ready, req1_ready}, exp_g);
      end
      next_cycle();
    end
    clr();
  endtask

  task automatic test_reset_mid_lock();
    req1_valid = 1; req1_lock = 1; req1_addr = 8'h05;
    @(negedge clk);
    next_cycle();
    req0_valid = 1; req0_addr = 8'h03;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL rml_pre: got %b want 01", {req0_ready, req1_ready});
    end
    next_cycle();
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, bram_en, rsp0_valid, rsp1_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL rml_rst: got rdy/en/rsp=%b want 00000",
               {req0_ready, req1_ready, bram_en, rsp0_valid, rsp1_valid});
    end
    next_cycle();
    rst = 0; req1_lock = 0;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rml_after: got rdy/rsp=%b want 1000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
    end
    next_cycle();
    clr();
    @(negedge clk);
    n_cmp++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL rml_rsp0: got %b want 10", {rsp0_valid, rsp1_valid});
    end
    next_cycle();
  endtask

  task automatic test_idle();
    clr();
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready, bram_en, bram_we, rsp0_valid, rsp1_valid} !== 6'b0) begin
        n_bad++;
        $display("FAIL idle cyc%0d: got %b want 000000", i,
                 {req0_ready, req1_ready, bram_en, bram_we, rsp0_valid, rsp1_valid});
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[3] = 8'h33;
    mem[5] = 8'h55;
    bram_rdata = 8'h00;
    rst = 1;
    clr();
    next_cycle();
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock0();
    test_lock1_max();
    test_reset_mid_lock();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
